pifo_cmd_dispatch: RTL and testbench

Upstream command stage for `PIFO_SRAM_TOP`. It accepts a single host command stream of push and pop requests, each tagged with a lane, and buffers them in per-lane queues. It then issues them as single-cycle `push`/`pop` strobes on the PIFO's per-level lane ports, together with `tree_id` and `push_data`. Issue is throttled per lane by the PIFO's `task_fifo_full` back-pressure and by an enforced minimum gap between consecutive operations on the same lane.

---
 rtl/pifo_cmd_dispatch.sv | 193 +++++++++++++++++++
 tb/tb_pifo_cmd_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_cmd_dispatch.sv
// pifo_cmd_dispatch: upstream command stage for PIFO_SRAM_TOP.
// Buffers a single host push/pop command stream into per-lane circular
// queues and issues each command as a one-cycle push/pop strobe on its
// lane. Issue is throttled per lane by task_fifo_full back-pressure and by
// a minimum idle gap after every issued op.
//
// Optional feature macro: PIFO_DISPATCH_POP_GUARD_EN
//   defined   - per-lane occupancy tracking; pops on an empty PIFO lane are
//               dropped and reported on o_underflow.
//   undefined - pops are always issued; o_underflow stays 0.
//
// Ports:
//   i_clk, i_arst        clock, asynchronous active-high reset
//   i_cmd_*              host command (valid, lane, pop, tree_id, data)
//   o_cmd_ready[LEVEL]   per-lane queue not full (registered)
//   i_task_fifo_full     per-lane back-pressure from the PIFO
//   o_push / o_pop       per-lane single-cycle strobes
//   o_tree_id            per-lane tree id of the issued op (0 when idle)
//   o_push_data          per-lane push data (0 when idle or on a pop)
//   o_underflow          per-lane pulse when a pop is discarded
//   o_idle               all queues empty and all lanes ready
module pifo_cmd_dispatch #(
    parameter int unsigned PTW     = 8,
    parameter int unsigned LEVEL   = 4,
    parameter int unsigned TIDW    = 2,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned MIN_GAP = 1
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_cmd_valid,
    output logic [LEVEL-1:0]           o_cmd_ready,
    input  logic [$clog2(LEVEL)-1:0]   i_cmd_lane,
    input  logic                       i_cmd_pop,
    input  logic [TIDW-1:0]            i_cmd_tree_id,
    input  logic [PTW-1:0]             i_cmd_data,
    input  logic [LEVEL-1:0]           i_task_fifo_full,
    output logic [LEVEL-1:0]           o_push,
    output logic [LEVEL-1:0]           o_pop,
    output logic [TIDW-1:0]            o_tree_id   [0:LEVEL-1],
    output logic [PTW-1:0]             o_push_data [0:LEVEL-1],
    output logic [LEVEL-1:0]           o_underflow,
    output logic                       o_idle
);

    localparam int unsigned LW = $clog2(LEVEL);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned GW = 3;
    localparam bit          NO_GAP = (MIN_GAP == 0);

    typedef struct packed {
        logic            pop;
        logic [TIDW-1:0] tree_id;
        logic [PTW-1:0]  data;
    } cmd_t;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } lane_state_t;

    cmd_t        mem        [0:LEVEL-1][0:QDEPTH-1];
    logic [PW-1:0] wr_ptr   [0:LEVEL-1];
    logic [PW-1:0] rd_ptr   [0:LEVEL-1];
    logic [CW-1:0] count    [0:LEVEL-1];
    logic [CW-1:0] count_next [0:LEVEL-1];
    lane_state_t state      [0:LEVEL-1];
    logic [GW-1:0] gap_cnt  [0:LEVEL-1];
    cmd_t        head       [0:LEVEL-1];
    cmd_t        wr_cmd;
    logic [LEVEL-1:0] wr_en;
    logic [LEVEL-1:0] rd_en;
    logic [LEVEL-1:0] idle_lane;

`ifdef PIFO_DISPATCH_POP_GUARD_EN
    localparam int unsigned OW = $clog2(QDEPTH * 16 + 1);
    localparam logic [OW-1:0] OCC_MAX = '1;
    logic [OW-1:0] occ [0:LEVEL-1];
`endif

    // Per-lane write/read enables, queue heads and next-cycle occupancy.
    always_comb begin
        wr_cmd = '{pop: i_cmd_pop, tree_id: i_cmd_tree_id, data: i_cmd_data};
        for (int j = 0; j < LEVEL; j++) begin
            wr_en[j]      = i_cmd_valid && (i_cmd_lane == LW'(j)) && o_cmd_ready[j];
            rd_en[j]      = (state[j] == ST_READY) && (count[j] != '0) && !i_task_fifo_full[j];
            head[j]       = mem[j][rd_ptr[j]];
            count_next[j] = count[j] + CW'(wr_en[j]) - CW'(rd_en[j]);
            // Lane is idle next cycle if its queue drains and it will be in READY.
            idle_lane[j]  = (count_next[j] == '0) &&
                            (rd_en[j] ? NO_GAP
                                      : ((state[j] == ST_READY) || (gap_cnt[j] <= GW'(1))));
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        for (int j = 0; j < LEVEL; j++) begin
            if (wr_en[j]) begin
                mem[j][wr_ptr[j]] <= wr_cmd;
            end
        end
    end

    // Queue pointers, lane FSMs and registered lane outputs.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_cmd_ready <= '1;
            o_push      <= '0;
            o_pop       <= '0;
            o_underflow <= '0;
            o_idle      <= 1'b1;
            for (int j = 0; j < LEVEL; j++) begin
                wr_ptr[j]      <= '0;
                rd_ptr[j]      <= '0;
                count[j]       <= '0;
                state[j]       <= ST_READY;
                gap_cnt[j]     <= '0;
                o_tree_id[j]   <= '0;
                o_push_data[j] <= '0;
`ifdef PIFO_DISPATCH_POP_GUARD_EN
                occ[j]         <= '0;
`endif
            end
        end else begin
            o_idle <= &idle_lane;
            for (int j = 0; j < LEVEL; j++) begin
                o_cmd_ready[j] <= (count_next[j] != CW'(QDEPTH));
                count[j]       <= count_next[j];
                if (wr_en[j]) begin
                    wr_ptr[j] <= wr_ptr[j] + PW'(1);
                end
                if (rd_en[j]) begin
                    rd_ptr[j] <= rd_ptr[j] + PW'(1);
                end

                o_push[j]      <= 1'b0;
                o_pop[j]       <= 1'b0;
                o_underflow[j] <= 1'b0;
                o_tree_id[j]   <= '0;
                o_push_data[j] <= '0;

                case (state[j])
                    ST_READY: begin
                        if (rd_en[j]) begin
                            if (head[j].pop) begin
`ifdef PIFO_DISPATCH_POP_GUARD_EN
                                // Pop on an empty PIFO lane is consumed but not issued.
                                if (occ[j] == '0) begin
                                    o_underflow[j] <= 1'b1;
                                end else begin
                                    o_pop[j]     <= 1'b1;
                                    o_tree_id[j] <= head[j].tree_id;
                                    occ[j]       <= occ[j] - OW'(1);
                                end
`else
                                o_pop[j]     <= 1'b1;
                                o_tree_id[j] <= head[j].tree_id;
`endif
                            end else begin
                                o_push[j]      <= 1'b1;
                                o_tree_id[j]   <= head[j].tree_id;
                                o_push_data[j] <= head[j].data;
`ifdef PIFO_DISPATCH_POP_GUARD_EN
                                if (occ[j] != OCC_MAX) begin
                                    occ[j] <= occ[j] + OW'(1);
                                end
`endif
                            end
                            if (!NO_GAP) begin
                                state[j]   <= ST_GAP;
                                gap_cnt[j] <= GW'(MIN_GAP);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt[j] <= GW'(1)) begin
                            state[j]   <= ST_READY;
                            gap_cnt[j] <= '0;
                        end else begin
                            gap_cnt[j] <= gap_cnt[j] - GW'(1);
                        end
                    end
                    default: begin
                        state[j] <= ST_READY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pifo_cmd_dispatch.sv
// Self-checking bench for pifo_cmd_dispatch: a queue/timestamp reference
// model is compared against every DUT output on every cycle, while directed
// scenarios pin known strobe counts, data and timing with literal values,
// followed by a randomized command/back-pressure phase.
module tb_pifo_cmd_dispatch;

    localparam int unsigned PTW     = 8;
    localparam int unsigned LEVEL   = 4;
    localparam int unsigned TIDW    = 2;
    localparam int unsigned QDEPTH  = 4;
    localparam int unsigned MIN_GAP = 1;
    localparam int unsigned OW      = $clog2(QDEPTH * 16 + 1);

    logic             clk = 1'b0;
    logic             arst;
    logic             cmd_valid;
    logic [LEVEL-1:0] cmd_ready;
    logic [1:0]       cmd_lane;
    logic             cmd_pop;
    logic [TIDW-1:0]  cmd_tree_id;
    logic [PTW-1:0]   cmd_data;
    logic [LEVEL-1:0] task_fifo_full;
    logic [LEVEL-1:0] push;
    logic [LEVEL-1:0] pop;
    logic [TIDW-1:0]  tree_id   [0:LEVEL-1];
    logic [PTW-1:0]   push_data [0:LEVEL-1];
    logic [LEVEL-1:0] underflow;
    logic             idle;

    always #5 clk = ~clk;

    pifo_cmd_dispatch #(
        .PTW(PTW), .LEVEL(LEVEL), .TIDW(TIDW), .QDEPTH(QDEPTH), .MIN_GAP(MIN_GAP)
    ) dut (
        .i_clk(clk),
        .i_arst(arst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_lane(cmd_lane),
        .i_cmd_pop(cmd_pop),
        .i_cmd_tree_id(cmd_tree_id),
        .i_cmd_data(cmd_data),
        .i_task_fifo_full(task_fifo_full),
        .o_push(push),
        .o_pop(pop),
        .o_tree_id(tree_id),
        .o_push_data(push_data),
        .o_underflow(underflow),
        .o_idle(idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit            pop;
        bit [TIDW-1:0] tid;
        bit [PTW-1:0]  data;
    } mcmd_t;

    mcmd_t            mq [LEVEL][$];
    mcmd_t            hc;
    int               ready_at [LEVEL];
    int               occ_m    [LEVEL];
    int               edge_n = 0;
    bit [LEVEL-1:0]   e_push, e_pop, e_under, e_ready;
    bit               e_idle;
    bit [TIDW-1:0]    e_tid  [LEVEL];
    bit [PTW-1:0]     e_data [LEVEL];

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int j = 0; j < LEVEL; j++) begin
                mq[j].delete();
                ready_at[j] = 0;
                occ_m[j]    = 0;
                e_tid[j]    = '0;
                e_data[j]   = '0;
            end
            e_push  = '0;
            e_pop   = '0;
            e_under = '0;
            e_ready = '1;
            e_idle  = 1'b1;
        end else begin
            edge_n++;
            e_push  = '0;
            e_pop   = '0;
            e_under = '0;
            for (int j = 0; j < LEVEL; j++) begin
                e_tid[j]  = '0;
                e_data[j] = '0;
                if (mq[j].size() > 0 && !task_fifo_full[j] && edge_n >= ready_at[j]) begin
                    hc = mq[j].pop_front();
                    ready_at[j] = edge_n + int'(MIN_GAP) + 1;
                    if (hc.pop) begin
`ifdef PIFO_DISPATCH_POP_GUARD_EN
                        if (occ_m[j] == 0) begin
                            e_under[j] = 1'b1;
                        end else begin
                            occ_m[j]--;
                            e_pop[j] = 1'b1;
                            e_tid[j] = hc.tid;
                        end
`else
                        e_pop[j] = 1'b1;
                        e_tid[j] = hc.tid;
`endif
                    end else begin
                        e_push[j] = 1'b1;
                        e_tid[j]  = hc.tid;
                        e_data[j] = hc.data;
                        if (occ_m[j] < (1 << OW) - 1) occ_m[j]++;
                    end
                end
            end
            if (cmd_valid && e_ready[cmd_lane]) begin
                mq[cmd_lane].push_back('{cmd_pop, cmd_tree_id, cmd_data});
            end
            e_idle = 1'b1;
            for (int j = 0; j < LEVEL; j++) begin
                e_ready[j] = (mq[j].size() < int'(QDEPTH));
                if (mq[j].size() != 0 || edge_n + 1 < ready_at[j]) e_idle = 1'b0;
            end
        end
    end

    // ---------------- compare + event logging ----------------
    int cyc = 0;
    int cnt_push [LEVEL];
    int cnt_pop  [LEVEL];
    int cnt_under[LEVEL];
    int first_push_cyc [LEVEL];
    int push_log_data [LEVEL][$];
    int push_log_cyc  [LEVEL][$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("cmd_ready", int'(cmd_ready), int'(e_ready));
        check("push", int'(push), int'(e_push));
        check("pop", int'(pop), int'(e_pop));
        check("underflow", int'(underflow), int'(e_under));
        check("idle", int'(idle), int'(e_idle));
        for (int j = 0; j < LEVEL; j++) begin
            check($sformatf("tree_id[%0d]", j), int'(tree_id[j]), int'(e_tid[j]));
            check($sformatf("push_data[%0d]", j), int'(push_data[j]), int'(e_data[j]));
            check($sformatf("push_pop_excl[%0d]", j), int'(push[j] & pop[j]), 0);
            if (push[j]) begin
                cnt_push[j]++;
                push_log_data[j].push_back(int'(push_data[j]));
                push_log_cyc[j].push_back(cyc);
                if (first_push_cyc[j] < 0) first_push_cyc[j] = cyc;
            end
            if (pop[j]) cnt_pop[j]++;
            if (underflow[j]) cnt_under[j]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int lane, bit p, int tid, int data);
        cmd_valid   = 1'b1;
        cmd_lane    = 2'(lane);
        cmd_pop     = p;
        cmd_tree_id = TIDW'(tid);
        cmd_data    = PTW'(data);
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic clear_logs();
        for (int j = 0; j < LEVEL; j++) begin
            cnt_push[j] = 0;
            cnt_pop[j] = 0;
            cnt_under[j] = 0;
            first_push_cyc[j] = -1;
            push_log_data[j].delete();
            push_log_cyc[j].delete();
        end
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget && !idle; i++) tick();
        check("wait_idle", int'(idle), 1);
    endtask

    int acc [LEVEL];
    int t1_acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        arst = 1'b1;
        cmd_valid = 1'b0;
        cmd_lane = '0;
        cmd_pop = 1'b0;
        cmd_tree_id = '0;
        cmd_data = '0;
        task_fifo_full = '0;
        clear_logs();
        repeat (3) tick();
        check("rst_ready", int'(cmd_ready), 15);
        check("rst_idle", int'(idle), 1);
        check("rst_push", int'(push), 0);
        check("rst_pop", int'(pop), 0);
        arst = 1'b0;
        tick();
        tick();

        // Three pushes on lane 2, spaced MIN_GAP+1 = 2 apart.
        clear_logs();
        t1_acc = cyc + 1;
        send(2, 0, 2, 1);
        send(2, 0, 2, 2);
        send(2, 0, 2, 3);
        repeat (10) tick();
        check("t1_count", cnt_push[2], 3);
        if (push_log_data[2].size() >= 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("t1_data%0d", i), push_log_data[2][i], i + 1);
            check("t1_latency", push_log_cyc[2][0], t1_acc + 1);
            check("t1_gap01", push_log_cyc[2][1] - push_log_cyc[2][0], 2);
            check("t1_gap12", push_log_cyc[2][2] - push_log_cyc[2][1], 2);
        end

        // Fill lane 0 under back-pressure; 5th command must be dropped.
        clear_logs();
        task_fifo_full[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 0, 1, 10 + i);
        check("t2_ready0", int'(cmd_ready[0]), 0);
        send(0, 0, 1, 14);
        repeat (3) tick();
        check("t2_held", cnt_push[0], 0);
        task_fifo_full[0] = 1'b0;
        repeat (15) tick();
        check("t2_count", cnt_push[0], 4);
        if (push_log_data[0].size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("t2_data%0d", i), push_log_data[0][i], 10 + i);
        end

        // Pop on untouched lane 1.
        clear_logs();
        send(1, 1, 3, 0);
        repeat (6) tick();
`ifdef PIFO_DISPATCH_POP_GUARD_EN
        check("t5_pop1", cnt_pop[1], 0);
        check("t5_under1", cnt_under[1], 1);
`else
        check("t5_pop1", cnt_pop[1], 1);
        check("t5_under1", cnt_under[1], 0);
`endif

        // Alternate push lane 0 / pop lane 2.
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            send(0, 0, 0, i + 1);
            send(2, 1, 1, 0);
        end
        repeat (12) tick();
        check("t3_push0", cnt_push[0], 3);
        check("t3_pop2", cnt_pop[2], 3);
        if (push_log_data[0].size() >= 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("t3_data%0d", i), push_log_data[0][i], i + 1);
        end

        // One command per lane on consecutive cycles.
        wait_idle(50);
        clear_logs();
        for (int j = 0; j < LEVEL; j++) begin
            acc[j] = cyc + 1;
            send(j, 0, j, 20 + j);
        end
        repeat (6) tick();
        for (int j = 0; j < LEVEL; j++) check($sformatf("t4_lat%0d", j), first_push_cyc[j], acc[j] + 1);

        // Randomized commands and back-pressure.
        for (int i = 0; i < 2000; i++) begin
            cmd_valid      = 1'($urandom_range(0, 1));
            cmd_lane       = 2'($urandom_range(0, LEVEL - 1));
            cmd_pop        = 1'($urandom_range(0, 2) == 0);
            cmd_tree_id    = TIDW'($urandom);
            cmd_data       = PTW'($urandom);
            task_fifo_full = LEVEL'($urandom & $urandom);
            tick();
        end
        cmd_valid = 1'b0;
        task_fifo_full = '0;
        repeat (30) tick();

        // Reset with commands queued on lane 3.
        wait_idle(50);
        task_fifo_full[3] = 1'b1;
        for (int i = 0; i < 3; i++) send(3, 0, 1, 5 + i);
        send(0, 0, 1, 7);
        @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        check("t6_push", int'(push), 0);
        check("t6_pop", int'(pop), 0);
        check("t6_under", int'(underflow), 0);
        check("t6_ready", int'(cmd_ready), 15);
        for (int j = 0; j < LEVEL; j++) begin
            check($sformatf("t6_tid%0d", j), int'(tree_id[j]), 0);
            check($sformatf("t6_data%0d", j), int'(push_data[j]), 0);
        end
        tick();
        tick();
        arst = 1'b0;
        task_fifo_full = '0;
        clear_logs();
        repeat (10) tick();
        check("t6_no_strobe3", cnt_push[3], 0);
        check("t6_idle", int'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
